mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - Initiator side of the data-memory port: sits between the CPU's load/store
//   stage and a word-addressed data memory that uses a req/ready handshake.
// - Turns CPU byte/half/word loads and stores into word transactions:
//   - loads return extracted, sign- or zero-extended data;
//   - sub-word stores use read-modify-write (RMW).
// - Stalls the CPU until each access completes.
// - Flags misaligned or illegal accesses without touching memory.
// PARAMETERS
// - AW   8   memory word-address width (2**AW words; byte address range 2**(AW+2))
// PORTS
// - clk           in   1   single clock, rising edge
// - rst_n         in   1   asynchronous, active-low reset
// - cpu_req       in   1   access request; held high by the CPU until cpu_done
// - cpu_we        in   1   1 = store, 0 = load
// - cpu_addr      in   32  byte address
// - cpu_wdata     in   32  store data; the sub-word is taken from the LSBs
// - cpu_size      in   2   00 = byte, 01 = half, 10 = word, 11 = illegal
// - cpu_unsigned  in   1   load is zero-extended when 1, sign-extended when 0
// - cpu_rdata     out  32  load result; valid while cpu_done = 1
// - cpu_done      out  1   one-cycle completion pulse (also pulses on error)
// - cpu_err       out  1   pulses together with cpu_done on a rejected access
// - cpu_stall     out  1   combinational: cpu_req & ~cpu_done
// - mem_req       out  1   memory request; held until mem_ready is seen
// - mem_we        out  1   memory write strobe (whole word)
// - mem_addr      out  AW  word address = cpu_addr[AW+1:2]
// - mem_wdata     out  32  write word
// - mem_ready     in   1   memory accepts/completes the request this cycle
// - mem_rdata     in   32  read word; valid in the cycle mem_ready = 1 and mem_we = 0
// BEHAVIOUR
// - Reset: every registered output = 0, FSM = IDLE. Asserting reset mid-access
//   abandons the transaction: mem_req drops immediately, no cpu_done is given.
// - FSM states: IDLE, RD, RMW_RD, RMW_WR, WR, DONE.
//   - IDLE + cpu_req: latch we/addr/wdata/size/unsigned, then check the access:
//     - illegal -> DONE with err = 1;
//     - load -> RD;
//     - word store -> WR;
//     - byte/half store -> RMW_RD.
//   - RD / RMW_RD: mem_req = 1, mem_we = 0. On mem_ready, capture mem_rdata;
//     RD -> DONE, RMW_RD -> RMW_WR.
//   - RMW_WR: mem_wdata = captured word with the target lane(s) replaced;
//     mem_we = 1; on mem_ready -> DONE.
//   - WR: mem_wdata = cpu_wdata, mem_we = 1; on mem_ready -> DONE.
//   - DONE: cpu_done = 1 for exactly one cycle; cpu_rdata/cpu_err valid; -> IDLE.
//     If cpu_req is still high in the following IDLE cycle, it is a new access.
// - Illegal access (checked in IDLE; flagged with cpu_err, no memory cycle):
//   - cpu_size = 11;
//   - half with addr[0] = 1;
//   - word with addr[1:0] != 0;
//   - any of cpu_addr[31:AW+2] nonzero.
// - Lanes are little-endian: byte n = bits [8n+7:8n], n = addr[1:0];
//   half at addr[1] = 1 = bits [31:16].
// - Load extension: byte/half are sign-extended from bit 7/15 unless
//   cpu_unsigned = 1. cpu_unsigned is ignored for word loads.
// - Latency from the cycle cpu_req is first seen (k = memory wait cycles):
//   - word load / word store: done at cycle 2+k;
//   - sub-word store: done at cycle 3+k1+k2;
//   - error: done at cycle 1.
// - mem_addr/mem_we/mem_wdata stay stable while mem_req = 1 and mem_ready = 0.
//   At most one outstanding memory request.
// - cpu_rdata holds its last value outside DONE; it is 0 after a store or error.
// STRUCTURE
// - Package mem_access_pkg:
//   - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
//   - FSM state encoding;
//   - function is_misaligned(size, addr[1:0]).
// - Sub-module mem_lane_align (combinational):
//   - extract: word, addr[1:0], size, unsigned -> load value;
//   - merge: old word, new data, addr[1:0], size -> write word.
// TESTING
// - Word load, addr 0x10, mem word 4 = 0x8899AABB, mem_ready tied 1
//   -> mem_addr = 4, cpu_done at cycle 2, cpu_rdata = 0x8899AABB.
// - lb addr 0x13, word = 0x8899AABB -> cpu_rdata = 0xFFFFFF88;
//   lhu addr 0x12 -> 0x00008899.
// - sb 0x5A to addr 0x11, old word 0x11223344
//   -> one read, then a write of 0x11225A44; cpu_done at cycle 3.
// - Misaligned lw at addr 0x06 -> cpu_err = cpu_done = 1 at cycle 1,
//   mem_req never asserted; cpu_size = 11 gives the same result.
// - mem_ready held low 5 cycles during WR
//   -> mem_req/mem_addr/mem_wdata stable, cpu_stall = 1 throughout, done 1 cycle later.
// - rst_n low during RMW_RD
//   -> mem_req = 0 at once, no write issued, no cpu_done; next access behaves normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access controller.
//   - cpu_size encodings (byte / half / word / illegal)
//   - FSM state type for mem_access_ctrl
//   - is_misaligned(): alignment check for a size and the two low address bits
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_WR,
    ST_DONE
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane steering for 32-bit memory words.
//   i_rd_word   : word read from memory (load path)
//   i_old_word  : word captured for read-modify-write
//   i_new_data  : CPU store data, sub-word taken from the LSBs
//   i_addr_lo   : byte address bits [1:0]
//   i_size      : access size code
//   i_unsigned  : zero-extend (1) or sign-extend (0) sub-word loads
//   o_load      : extracted and extended load value
//   o_merge     : i_old_word with the addressed lane(s) replaced
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_new_data,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [4:0]  w_sh;
  logic [31:0] w_shift;
  logic [31:0] w_mask;
  logic [31:0] w_lane;

  assign w_sh    = {i_addr_lo, 3'b000};
  // Bring the addressed lane down to bit 0; word accesses are aligned so the
  // shift is zero for them.
  assign w_shift = i_rd_word >> w_sh;

  always_comb begin
    o_load = w_shift;
    case (i_size)
      SZ_BYTE: o_load = {{24{~i_unsigned & w_shift[7]}},  w_shift[7:0]};
      SZ_HALF: o_load = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
      default: o_load = w_shift;
    endcase
  end

  always_comb begin
    w_mask = '1;
    w_lane = i_new_data;
    case (i_size)
      SZ_BYTE: begin
        w_mask = 32'h0000_00FF << w_sh;
        w_lane = {24'h0, i_new_data[7:0]} << w_sh;
      end
      SZ_HALF: begin
        w_mask = 32'h0000_FFFF << w_sh;
        w_lane = {16'h0, i_new_data[15:0]} << w_sh;
      end
      default: begin
        w_mask = '1;
        w_lane = i_new_data;
      end
    endcase
    o_merge = (i_old_word & ~w_mask) | (w_lane & w_mask);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator between the CPU load/store stage and a word-addressed
// memory with a req/ready handshake. Byte/half loads are extracted and
// extended; byte/half stores use read-modify-write. Illegal or misaligned
// accesses complete with cpu_err and never touch memory.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cpu_req..cpu_unsigned : CPU request, held until cpu_done
//   cpu_rdata         : load result, held between accesses (0 after store/error)
//   cpu_done/cpu_err  : one-cycle completion pulse / rejection flag
//   cpu_stall         : cpu_req & ~cpu_done
//   mem_req..mem_wdata: memory request, stable until mem_ready
//   mem_ready/mem_rdata : memory handshake and read data
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [1:0]    cpu_size,
  input  logic          cpu_unsigned,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic          cpu_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic [31:0]   mem_rdata
);

  state_e        r_state;
  state_e        w_next;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [31:0]   r_word;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_illegal;
  logic [31:0]   w_load;
  logic [31:0]   w_merge;

  assign w_illegal = (cpu_size == SZ_ILL)
                   | is_misaligned(cpu_size, cpu_addr[1:0])
                   | (|cpu_addr[31:AW+2]);

  mem_lane_align u_align (
    .i_rd_word  (mem_rdata),
    .i_old_word (r_word),
    .i_new_data (r_wdata),
    .i_addr_lo  (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // The store direction is carried by the state chosen in IDLE, so cpu_we
  // needs no separate register.
  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    cpu_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) begin
          if (w_illegal)             w_next = ST_DONE;
          else if (!cpu_we)          w_next = ST_RD;
          else if (cpu_size == SZ_WORD) w_next = ST_WR;
          else                       w_next = ST_RMW_RD;
        end
      end
      ST_RD: begin
        mem_req = 1'b1;
        if (mem_ready) w_next = ST_DONE;
      end
      ST_RMW_RD: begin
        mem_req = 1'b1;
        if (mem_ready) w_next = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = w_merge;
        if (mem_ready) w_next = ST_DONE;
      end
      ST_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = r_wdata;
        if (mem_ready) w_next = ST_DONE;
      end
      ST_DONE: begin
        cpu_done = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_word  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr[AW+1:0];
            r_wdata <= cpu_wdata;
            r_size  <= cpu_size;
            r_uns   <= cpu_unsigned;
            r_err   <= w_illegal;
            if (w_illegal) r_rdata <= '0;
          end
        end
        ST_RD:     if (mem_ready) r_rdata <= w_load;
        ST_RMW_RD: if (mem_ready) r_word  <= mem_rdata;
        ST_RMW_WR,
        ST_WR:     if (mem_ready) r_rdata <= '0;
        default: ;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_err   = cpu_done & r_err;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign mem_addr  = r_addr[AW+1:2];

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int AW = 8;

  logic          clk;
  logic          rst_n;
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [1:0]    cpu_size;
  logic          cpu_unsigned;
  logic [31:0]   cpu_rdata;
  logic          cpu_done;
  logic          cpu_err;
  logic          cpu_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [31:0]   mem_rdata;

  mem_access_ctrl #(.AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_size     (cpu_size),
    .cpu_unsigned (cpu_unsigned),
    .cpu_rdata    (cpu_rdata),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .cpu_stall    (cpu_stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  logic [31:0] bmem [256];
  bit          init_done;
  int          wcnt;
  int          rd_cnt;
  int          wr_cnt;
  int          wait_cfg;

  assign mem_ready = mem_req && (wcnt >= wait_cfg);
  assign mem_rdata = (mem_req && mem_ready && !mem_we) ? bmem[mem_addr] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) bmem[i] <= (32'h0101_0101 * i) ^ 32'hC300_0000;
      bmem[4]   <= 32'h8899_AABB;
      init_done <= 1'b1;
    end else if (mem_req && mem_ready) begin
      if (mem_we) begin
        bmem[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  // ---------------- reference model ----------------
  function automatic void model(input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [1:0] sz,
                                input logic uns, input logic [31:0] old, input int k,
                                output logic err, output logic [31:0] rdata,
                                output logic [31:0] nw, output int lat,
                                output int nrd, output int nwr);
    int idx;
    int nb;
    logic [31:0] v;
    idx   = int'(addr[1:0]);
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err   = (sz == 2'd3) || ((idx % nb) != 0) || (addr >= 32'd1024);
    rdata = 32'h0;
    nw    = old;
    nrd   = 0;
    nwr   = 0;
    lat   = 1;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = old >> (8 * idx);
      if (nb == 1) begin
        v = v & 32'hFF;
        if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (nb == 2) begin
        v = v & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      rdata = v;
      lat   = 2 + k;
      nrd   = 1;
    end else begin
      for (int b = 0; b < nb; b++) nw[8*(idx+b) +: 8] = wd[8*b +: 8];
      nwr = 1;
      if (nb == 4) lat = 2 + k;
      else begin
        lat = 3 + 2 * k;
        nrd = 1;
      end
    end
  endfunction

  // ---------------- shared expectations (written by the driver only) ----------------
  logic        active;
  int          cyc;
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic [31:0] exp_new;
  logic [7:0]  exp_widx;
  int          exp_lat;
  int          exp_nrd;
  int          exp_nwr;
  logic        exp_we;
  logic        lit_en;
  logic [31:0] lit_val;
  int          rd_base;
  int          wr_base;
  logic        tmo;
  logic        chk_end;
  logic        chk_idle_zero;
  logic        chk_mreq_hi;

  // ---------------- compare process ----------------
  int          n_cmp;
  int          n_fail;
  logic        p_req, p_ready, p_we, p_rst;
  logic [7:0]  p_addr;
  logic [31:0] p_wdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_idle_zero) begin
      check("rst_done",  32'(cpu_done),  32'd0);
      check("rst_err",   32'(cpu_err),   32'd0);
      check("rst_rdata", cpu_rdata,      32'd0);
      check("rst_mreq",  32'(mem_req),   32'd0);
      check("rst_mwe",   32'(mem_we),    32'd0);
      check("rst_maddr", 32'(mem_addr),  32'd0);
      check("rst_mwd",   mem_wdata,      32'd0);
      check("rst_stall", 32'(cpu_stall), 32'd0);
    end
    if (chk_mreq_hi) check("rmw_rd_req", 32'(mem_req), 32'd1);
    if (active) begin
      check("stall", 32'(cpu_stall), (cyc < exp_lat) ? 32'd1 : 32'd0);
      if (cyc < exp_lat) begin
        check("early_done", 32'(cpu_done), 32'd0);
      end else if (cyc == exp_lat) begin
        check("done",  32'(cpu_done), 32'd1);
        check("err",   32'(cpu_err),  32'(exp_err));
        check("rdata", cpu_rdata,     exp_rdata);
        if (lit_en && !exp_we) check("lit_rdata", cpu_rdata, lit_val);
      end
      if (exp_err) check("err_no_mreq", 32'(mem_req), 32'd0);
      if (mem_req && mem_ready) begin
        check("maddr", 32'(mem_addr), 32'(exp_widx));
        if (exp_nwr == 0) check("no_write", 32'(mem_we), 32'd0);
        else if (mem_we)  check("mwdata", mem_wdata, exp_new);
      end
    end
    if (tmo) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got no cpu_done expected done at cycle %0d", exp_lat);
    end
    if (chk_end) begin
      check("mem_word",  bmem[exp_widx], exp_new);
      check("rd_count",  32'(rd_cnt - rd_base), 32'(exp_nrd));
      check("wr_count",  32'(wr_cnt - wr_base), 32'(exp_nwr));
      check("rdata_hold", cpu_rdata, exp_rdata);
      check("idle_done", 32'(cpu_done), 32'd0);
      if (lit_en && exp_we) check("lit_mem", bmem[exp_widx], lit_val);
    end
    if (rst_n && p_rst && p_req && !p_ready) begin
      check("hold_req",   32'(mem_req),  32'd1);
      check("hold_addr",  32'(mem_addr), 32'(p_addr));
      check("hold_we",    32'(mem_we),   32'(p_we));
      check("hold_wdata", mem_wdata,     p_wdata);
    end
    p_req   <= mem_req;
    p_ready <= mem_ready;
    p_we    <= mem_we;
    p_addr  <= mem_addr;
    p_wdata <= mem_wdata;
    p_rst   <= rst_n;
  end

  // ---------------- driver ----------------
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns, input int k,
                        input logic len, input logic [31:0] lv);
    logic        e;
    logic [31:0] rd;
    logic [31:0] nw;
    int          lat;
    int          nr;
    int          nwv;
    bit          done;
    @(posedge clk); #1;
    model(we, addr, wd, sz, uns, bmem[addr[9:2]], k, e, rd, nw, lat, nr, nwv);
    exp_widx  = addr[9:2];
    exp_err   = e;
    exp_rdata = rd;
    exp_new   = nw;
    exp_lat   = lat;
    exp_nrd   = nr;
    exp_nwr   = nwv;
    exp_we    = we;
    lit_en    = len;
    lit_val   = lv;
    wait_cfg  = k;
    rd_base   = rd_cnt;
    wr_base   = wr_cnt;
    cpu_we       = we;
    cpu_addr     = addr;
    cpu_wdata    = wd;
    cpu_size     = sz;
    cpu_unsigned = uns;
    cpu_req      = 1'b1;
    cyc          = 0;
    active       = 1'b1;
    done         = 1'b0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      done = cpu_done;
    end
    if (!done) tmo = 1'b1;
    @(negedge clk); #1;
    cpu_req = 1'b0;
    active  = 1'b0;
    tmo     = 1'b0;
    @(posedge clk); #1;
    chk_end = 1'b1;
    @(negedge clk); #1;
    chk_end = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_size = 2'd0; cpu_unsigned = 1'b0;
    active = 1'b0; cyc = 0; exp_err = 1'b0; exp_rdata = '0; exp_new = '0;
    exp_widx = '0; exp_lat = 0; exp_nrd = 0; exp_nwr = 0; exp_we = 1'b0;
    lit_en = 1'b0; lit_val = '0; rd_base = 0; wr_base = 0; tmo = 1'b0;
    chk_end = 1'b0; chk_mreq_hi = 1'b0; wait_cfg = 0;
    chk_idle_zero = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk_idle_zero = 1'b0;

    // loads from word 4 = 0x8899AABB
    access(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h8899_AABB);
    access(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, 1'b1, 32'hFFFF_FF88);
    access(1'b0, 32'h12, 32'h0, 2'd1, 1'b1, 0, 1'b1, 32'h0000_8899);
    access(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 1, 1'b1, 32'hFFFF_8899);
    access(1'b0, 32'h11, 32'h0, 2'd0, 1'b1, 0, 1'b1, 32'h0000_00AA);
    access(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 2, 1'b1, 32'hFFFF_FFBB);
    access(1'b0, 32'h10, 32'h0, 2'd2, 1'b1, 0, 1'b1, 32'h8899_AABB);
    // stores
    access(1'b1, 32'h10, 32'h1122_3344, 2'd2, 1'b0, 0, 1'b1, 32'h1122_3344);
    access(1'b1, 32'h11, 32'hFFFF_FF5A, 2'd0, 1'b0, 0, 1'b1, 32'h1122_5A44);
    access(1'b1, 32'h12, 32'h1234_BEEF, 2'd1, 1'b0, 2, 1'b1, 32'hBEEF_5A44);
    access(1'b1, 32'h20, 32'hCAFE_F00D, 2'd2, 1'b0, 5, 1'b1, 32'hCAFE_F00D);
    // rejected accesses
    access(1'b0, 32'h06, 32'h0, 2'd2, 1'b0, 0, 1'b0, 32'h0);
    access(1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 0, 1'b0, 32'h0);
    access(1'b0, 32'h01, 32'h0, 2'd1, 1'b0, 0, 1'b0, 32'h0);
    access(1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 0, 1'b0, 32'h0);
    access(1'b1, 32'h8000_0000, 32'h5555_5555, 2'd2, 1'b0, 0, 1'b0, 32'h0);
    // top of the address range
    access(1'b0, 32'h3FC, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'h3CFF_FFFF);
    access(1'b1, 32'h3FF, 32'h0000_00EE, 2'd0, 1'b0, 1, 1'b1, 32'hEEFF_FFFF);
    access(1'b0, 32'h3FF, 32'h0, 2'd0, 1'b1, 0, 1'b1, 32'h0000_00EE);
    access(1'b0, 32'h3FF, 32'h0, 2'd0, 1'b0, 0, 1'b1, 32'hFFFF_FFEE);

    // reset while a byte store waits in its read phase
    @(posedge clk); #1;
    exp_widx = 8'h08; exp_new = bmem[8]; exp_rdata = '0;
    exp_nrd = 0; exp_nwr = 0; exp_we = 1'b1; lit_en = 1'b0;
    rd_base = rd_cnt; wr_base = wr_cnt; wait_cfg = 4;
    cpu_we = 1'b1; cpu_addr = 32'h21; cpu_wdata = 32'h77; cpu_size = 2'd0;
    cpu_unsigned = 1'b0; cpu_req = 1'b1;
    @(posedge clk); #1;
    chk_mreq_hi = 1'b1;
    @(negedge clk); #1;
    chk_mreq_hi = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; cpu_req = 1'b0; chk_idle_zero = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk_idle_zero = 1'b0;
    @(posedge clk); #1;
    chk_end = 1'b1;
    @(negedge clk); #1;
    chk_end = 1'b0;

    // normal operation after reset
    access(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1'b1, 32'hBEEF_5A44);
    access(1'b0, 32'h10, 32'h0, 2'd1, 1'b0, 1, 1'b1, 32'h0000_5A44);
    access(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 3, 1'b1, 32'hCAFE_F00D);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
